// File: rtl/spdif_tx_param.sv
// spdif_tx_param: IEC 60958 consumer S/PDIF transmitter, SAMPLE_W 16..24.
// Define SPDIF_TX_CHSTAT_EN to carry consumer channel status on the C bit.
module spdif_tx_param #(
   parameter int unsigned SAMPLE_W   = 24,
   parameter logic [3:0]  CS_FS_CODE = 4'h2,
   parameter logic        CS_COPY    = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  bit_out_en_i,
   input  logic [2*SAMPLE_W-1:0] sample_i,
   input  logic                  sample_valid_i,
   output logic                  sample_ready_o,
   output logic                  spdif_o,
   output logic                  underrun_o,
   output logic                  block_start_o
);
   localparam int unsigned PAD = 24 - SAMPLE_W;

   logic [5:0]            r_hb;
   logic [8:0]            r_sf;
   logic [2*SAMPLE_W-1:0] r_buf;
   logic                  r_buf_full;
   logic [SAMPLE_W-1:0]   r_work_r;
   logic                  r_work_v;
   logic [7:0]            r_pre;
   logic [31:0]           r_word;
   logic                  r_lvl;
   logic                  r_spdif;
   logic                  r_underrun;
   logic                  r_block;

   logic                  w_load;
   logic                  w_frame;
   logic                  w_accept;
   logic                  w_c;
   logic                  w_v;
   logic                  w_par;
   logic [SAMPLE_W-1:0]   w_smp;
   logic [23:0]           w_aud;
   logic [7:0]            w_pre;
   logic [31:0]           w_word;

`ifdef SPDIF_TX_CHSTAT_EN
   logic [7:0] w_cs_idx;
   always_comb begin
      w_cs_idx = r_sf[8:1];
      w_c = 1'b0;
      if (w_cs_idx == 8'd2)
         w_c = CS_COPY;
      else if (w_cs_idx >= 8'd24 && w_cs_idx <= 8'd27)
         w_c = CS_FS_CODE[w_cs_idx[1:0]];
   end
`else
   assign w_c = 1'b0 & (CS_COPY | (|CS_FS_CODE));
`endif

   // Left subframe reads the holding buffer directly on the frame-start load.
   always_comb begin
      w_load   = bit_out_en_i && (r_hb == 6'd0);
      w_frame  = w_load && !r_sf[0];
      w_accept = sample_valid_i && !r_buf_full;
      if (!r_sf[0]) begin
         w_smp = r_buf_full ? r_buf[SAMPLE_W-1:0] : '0;
         w_v   = !r_buf_full;
      end else begin
         w_smp = r_work_r;
         w_v   = r_work_v;
      end
      w_aud = 24'(w_smp) << PAD;
      if (r_sf == 9'd0)
         w_pre = 8'b11101000;
      else if (r_sf[0])
         w_pre = 8'b11100100;
      else
         w_pre = 8'b11100010;
      w_par  = ^{w_c, 1'b0, w_v, w_aud};
      w_word = {w_par, w_c, 1'b0, w_v, w_aud, 4'b0000};
   end

   always_ff @(posedge clk_i) begin
      r_underrun <= 1'b0;
      r_block    <= 1'b0;
      if (rst_i) begin
         r_hb       <= '0;
         r_sf       <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_work_r   <= '0;
         r_work_v   <= 1'b1;
         r_pre      <= '0;
         r_word     <= '0;
         r_lvl      <= 1'b0;
         r_spdif    <= 1'b0;
      end else begin
         if (w_frame) begin
            r_work_r   <= r_buf_full ? r_buf[2*SAMPLE_W-1:SAMPLE_W] : '0;
            r_work_v   <= !r_buf_full;
            r_underrun <= !r_buf_full;
         end
         if (w_frame && r_buf_full) begin
            r_buf_full <= 1'b0;
         end else if (w_accept) begin
            r_buf      <= sample_i;
            r_buf_full <= 1'b1;
         end
         if (bit_out_en_i) begin
            r_hb <= r_hb + 6'd1;
            if (r_hb == 6'd63)
               r_sf <= (r_sf == 9'd383) ? 9'd0 : r_sf + 9'd1;
            if (w_load) begin
               r_pre   <= w_pre;
               r_word  <= w_word;
               r_lvl   <= r_spdif;
               r_block <= (r_sf == 9'd0);
               r_spdif <= w_pre[7] ^ r_spdif;
            end else if (r_hb < 6'd8) begin
               r_spdif <= r_pre[~r_hb[2:0]] ^ r_lvl;
            end else if (!r_hb[0]) begin
               r_spdif <= ~r_spdif;
            end else begin
               r_spdif <= r_spdif ^ r_word[r_hb[5:1]];
            end
         end
      end
   end

   assign sample_ready_o = ~r_buf_full;
   assign spdif_o        = r_spdif;
   assign underrun_o     = r_underrun;
   assign block_start_o  = r_block;
endmodule

// File: tb/tb_spdif_tx_param.sv
// tb_spdif_tx_param: drives 24-bit and 16-bit instances of spdif_tx_param,
// decodes the BMC line and compares each subframe to a frame-level model.
`timescale 1ns/1ps
module tb_spdif_tx_param;
   localparam logic [3:0] FS = 4'h2;
   localparam logic       CP = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strobe = 1'b0;
   logic        valid = 1'b0;
   logic [47:0] smp = '0;
   logic [31:0] smp16;
   logic [1:0]  spd, rdy, und, blk;

   always #5 clk = ~clk;
   assign smp16 = {smp[39:24], smp[15:0]};

   spdif_tx_param #(.SAMPLE_W(24), .CS_FS_CODE(FS), .CS_COPY(CP)) u24 (
      .clk_i(clk), .rst_i(rst), .bit_out_en_i(strobe),
      .sample_i(smp), .sample_valid_i(valid), .sample_ready_o(rdy[0]),
      .spdif_o(spd[0]), .underrun_o(und[0]), .block_start_o(blk[0]));

   spdif_tx_param #(.SAMPLE_W(16), .CS_FS_CODE(FS), .CS_COPY(CP)) u16 (
      .clk_i(clk), .rst_i(rst), .bit_out_en_i(strobe),
      .sample_i(smp16), .sample_valid_i(valid), .sample_ready_o(rdy[1]),
      .spdif_o(spd[1]), .underrun_o(und[1]), .block_start_o(blk[1]));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic bit cs_bit(input int k);
      bit b;
      b = 1'b0;
`ifdef SPDIF_TX_CHSTAT_EN
      if (k == 2) b = CP;
      if (k >= 24 && k <= 27) b = FS[k-24];
`endif
      return b;
   endfunction

   // Frame-level model: half-bit index, handshake buffer, current frame content.
   int          m_n = 0, m_hb = 0, m_sf = 0, m_acc = 0;
   int          buf_tag = 0, cur_tag = -1, dacc = 0;
   bit          m_sb = 0, m_rst = 0, m_full = 0, e_und = 0, e_blk = 0;
   bit          cur_v = 1, hold_ok = 0;
   logic [23:0] buf_l = '0, buf_r = '0, cur_l = '0, cur_r = '0;

   always @(posedge clk) begin
      bit acc, fs;
      acc = valid && !m_full;
      fs = 0;
      m_sb = 0; e_und = 0; e_blk = 0;
      m_rst = rst;
      if (rst) begin
         m_n = 0; m_full = 0; hold_ok = 0; dacc = 0;
      end else begin
         if (!valid) hold_ok = 0;
         if (strobe) begin
            m_sb = 1;
            m_hb = m_n % 64;
            m_sf = (m_n / 64) % 384;
            if (m_hb == 0 && m_sf == 0) e_blk = 1;
            if (m_hb == 0 && m_sf % 2 == 0) begin
               fs = 1;
               if (m_full) begin
                  cur_l = buf_l; cur_r = buf_r; cur_v = 0; cur_tag = buf_tag;
               end else begin
                  cur_l = '0; cur_r = '0; cur_v = 1; cur_tag = -1; e_und = 1;
               end
            end
            m_n = (m_n + 1) % (64 * 384);
         end
         if (fs) begin
            if (hold_ok) chk("acc_per_frame", dacc, 1);
            dacc = 0;
            hold_ok = valid;
         end
         if (valid && rdy[0]) dacc++;
         if (fs && m_full) begin
            m_full = 0;
         end else if (acc) begin
            m_full = 1; buf_l = smp[23:0]; buf_r = smp[47:24];
            buf_tag = m_acc; m_acc++;
         end
      end
   end

   // Line decoder and per-subframe comparison.
   logic [63:0]  hbuf [2];
   bit           st [2];
   bit           last [2];
   logic [23:0]  dec_aud [2][2];
   bit           dec_p [2][2];
   bit           dec_v [2][2];
   int           done_tag = -2, dec_frame = 0;
   logic [191:0] cs_got = '0, cs_seen = '0;

   task automatic decode(input int d);
      logic [7:0]  pat, gp;
      logic [31:0] sl;
      logic [23:0] ea;
      bit          bmc_ok, ec, ep;
      int          ch;
      ch = m_sf % 2;
      pat = (m_sf == 0) ? 8'hE8 : (ch == 1) ? 8'hE4 : 8'hE2;
      for (int i = 0; i < 8; i++) gp[7-i] = hbuf[d][i] ^ st[d];
      sl = '0;
      bmc_ok = 1;
      for (int s = 4; s < 32; s++) begin
         if (hbuf[d][2*s] == hbuf[d][2*s-1]) bmc_ok = 0;
         sl[s] = hbuf[d][2*s] ^ hbuf[d][2*s+1];
      end
      ea = (ch == 1) ? cur_r : cur_l;
      if (d == 1) ea = {ea[15:0], 8'h00};
      ec = cs_bit(m_sf / 2);
      ep = ^{ea, cur_v, 1'b0, ec};
      chk(d ? "pre16" : "pre24", gp, pat);
      chk(d ? "bmc16" : "bmc24", bmc_ok, 1);
      chk(d ? "aud16" : "aud24", sl[27:4], ea);
      chk(d ? "v16" : "v24", sl[28], cur_v);
      chk(d ? "u16" : "u24", sl[29], 0);
      chk(d ? "c16" : "c24", sl[30], ec);
      chk(d ? "p16" : "p24", sl[31], ep);
      chk(d ? "even16" : "even24", $countones(sl[31:4]) % 2, 0);
      chk(d ? "end16" : "end24", hbuf[d][63], st[d]);
      dec_aud[d][ch] = sl[27:4];
      dec_p[d][ch] = sl[31];
      dec_v[d][ch] = sl[28];
      if (d == 0) begin
         cs_got[m_sf/2] = sl[30];
         cs_seen[m_sf/2] = 1'b1;
         if (ch == 0) dec_frame = m_sf / 2;
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk(d ? "ready16" : "ready24", rdy[d], !m_full);
         chk(d ? "under16" : "under24", und[d], e_und);
         chk(d ? "block16" : "block24", blk[d], e_blk);
         if (m_rst) begin
            last[d] = 0;
         end else if (m_sb) begin
            if (m_hb == 0) st[d] = last[d];
            hbuf[d][m_hb] = spd[d];
            last[d] = spd[d];
            if (m_hb == 63) decode(d);
         end
      end
      if (!m_rst && m_sb && m_hb == 63 && m_sf % 2 == 1) done_tag = cur_tag;
   end

   // Stimulus
   typedef struct {
      logic [23:0] l, r;
      bit          pl, pr;
      logic [23:0] al, ar;
      bit          pl16, pr16;
   } vec_t;

   int mode = 0;
   int cyc_n = 0;

   task automatic cyc();
      @(negedge clk);
      #1;
      cyc_n++;
      case (mode)
         0: strobe = (cyc_n % 4 == 0);
         1: strobe = ($urandom_range(0, 2) == 0);
         default: strobe = 1'b1;
      endcase
   endtask

   task automatic push(input logic [23:0] l, input logic [23:0] r, output int tag);
      for (int i = 0; i < 2000 && m_full; i++) cyc();
      chk("push_wait", m_full, 0);
      valid = 1'b1;
      smp = {r, l};
      tag = m_acc;
      cyc();
      valid = 1'b0;
   endtask

   task automatic wait_tag(input int tag);
      for (int i = 0; i < 3000 && done_tag != tag; i++) cyc();
      chk("tag_wait", done_tag, tag);
   endtask

   task automatic wait_load(input string nm);
      int i;
      i = 0;
      do begin
         cyc();
         i++;
      end while (!(m_sb && m_hb == 0) && i < 2000);
      chk(nm, m_sb && m_hb == 0, 1);
   endtask

   initial begin
      vec_t         tbl [5];
      int           tag;
      int           k;
      bit           c;
      logic [191:0] cs_exp;
      tbl[0] = '{24'h800001, 24'h7FFFFF, 1'b0, 1'b1, 24'h000100, 24'hFFFF00, 1'b1, 1'b0};
      tbl[1] = '{24'h00A5A5, 24'h000000, 1'b0, 1'b0, 24'hA5A500, 24'h000000, 1'b0, 1'b0};
      tbl[2] = '{24'hFFFFFF, 24'h000001, 1'b0, 1'b1, 24'hFFFF00, 24'h000100, 1'b0, 1'b1};
      tbl[3] = '{24'h123456, 24'hABCDEF, 1'b1, 1'b1, 24'h345600, 24'hCDEF00, 1'b1, 1'b0};
      tbl[4] = '{24'h000000, 24'h800000, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0};

      rst = 1'b1;
      repeat (3) cyc();
      for (int d = 0; d < 2; d++) begin
         chk("rst_spdif", spd[d], 0);
         chk("rst_ready", rdy[d], 1);
         chk("rst_under", und[d], 0);
         chk("rst_block", blk[d], 0);
      end
      rst = 1'b0;

      // Idle line: underrun frames, frame 0 preamble Z.
      mode = 0;
      wait_load("t1_load");
      chk("t1_block", blk[0], 1);
      chk("t1_under", und[0], 1);
      repeat (2 * 512) cyc();
      chk("t1_tag", done_tag, -1);

      // Table vectors on both sample widths.
      mode = 2;
      for (int i = 0; i < 5; i++) begin
         push(tbl[i].l, tbl[i].r, tag);
         wait_tag(tag);
         c = cs_bit(dec_frame);
         chk("tbl_l24", dec_aud[0][0], tbl[i].l);
         chk("tbl_r24", dec_aud[0][1], tbl[i].r);
         chk("tbl_pl24", dec_p[0][0], tbl[i].pl ^ c);
         chk("tbl_pr24", dec_p[0][1], tbl[i].pr ^ c);
         chk("tbl_l16", dec_aud[1][0], tbl[i].al);
         chk("tbl_r16", dec_aud[1][1], tbl[i].ar);
         chk("tbl_pl16", dec_p[1][0], tbl[i].pl16 ^ c);
         chk("tbl_pr16", dec_p[1][1], tbl[i].pr16 ^ c);
         chk("tbl_v", {dec_v[0][0], dec_v[0][1], dec_v[1][0], dec_v[1][1]}, 0);
      end

      // Valid held with changing data under irregular strobes.
      mode = 1;
      valid = 1'b1;
      repeat (12 * 384) begin
         smp = 48'({$urandom(), $urandom()});
         cyc();
      end
      valid = 1'b0;
      repeat (600) cyc();

      // Reset in the middle of a subframe.
      mode = 2;
      k = 0;
      do begin
         cyc();
         k++;
      end while (!(m_sb && m_hb == 37) && k < 2000);
      chk("t5_hb37", m_hb, 37);
      rst = 1'b1;
      cyc();
      for (int d = 0; d < 2; d++) begin
         chk("t5_spdif", spd[d], 0);
         chk("t5_ready", rdy[d], 1);
      end
      rst = 1'b0;
      wait_load("t5_load");
      chk("t5_block24", blk[0], 1);
      chk("t5_block16", blk[1], 1);

      // Accept coincident with an empty-buffer frame start.
      k = 0;
      do begin
         cyc();
         k++;
      end while (!(m_n % 64 == 0 && (m_n / 64) % 2 == 0 && !m_full) && k < 2000);
      valid = 1'b1;
      smp = {24'h5A5A5A, 24'hC3C3C3};
      tag = m_acc;
      cyc();
      valid = 1'b0;
      chk("co_under24", und[0], 1);
      chk("co_under16", und[1], 1);
      chk("co_ready", rdy[0], 0);
      wait_tag(tag);
      chk("co_l24", dec_aud[0][0], 24'hC3C3C3);
      chk("co_r24", dec_aud[0][1], 24'h5A5A5A);

      // Full channel-status block.
      cs_got = '0;
      cs_seen = '0;
      repeat (196 * 128) cyc();
      for (int i = 0; i < 192; i++) cs_exp[i] = cs_bit(i);
      for (int j = 0; j < 3; j++) begin
         chk("cs_seen", cs_seen[j*64 +: 64], {64{1'b1}});
         chk("cs_block", cs_got[j*64 +: 64], cs_exp[j*64 +: 64]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
